// File: rtl/riego_pkg.sv
// Shared state codes and default thresholds for the irrigation controller.
package riego_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_REGANDO = 2'd2,
    ST_LOCKOUT = 2'd3
  } estado_t;

  localparam int unsigned DEF_HUM_W     = 12;
  localparam int unsigned DEF_DRY_TH    = 1000;
  localparam int unsigned DEF_WET_TH    = 2000;
  localparam int unsigned DEF_N_CONFIRM = 4;
  localparam int unsigned DEF_MIN_ON    = 50_000_000;
  localparam int unsigned DEF_MAX_ON    = 1_500_000_000;
  localparam int unsigned DEF_LOCKOUT   = 500_000_000;

endpackage

// File: rtl/contador_ciclos.sv
// Saturating cycle counter with synchronous clear and terminal-count flag.
module contador_ciclos #(
  parameter int unsigned W  = 8,
  parameter int unsigned TC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign tc_c = (count == W'(TC));

endmodule

// File: rtl/control_riego.sv
// Soil-moisture irrigation controller: confirm dryness, water with min/max time, then rest.
module control_riego
  import riego_pkg::*;
#(
  parameter int unsigned HUM_W     = DEF_HUM_W,
  parameter int unsigned DRY_TH    = DEF_DRY_TH,
  parameter int unsigned WET_TH    = DEF_WET_TH,
  parameter int unsigned N_CONFIRM = DEF_N_CONFIRM,
  parameter int unsigned MIN_ON    = DEF_MIN_ON,
  parameter int unsigned MAX_ON    = DEF_MAX_ON,
  parameter int unsigned LOCKOUT   = DEF_LOCKOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             hum_valid,
  input  logic [HUM_W-1:0] hum,
  input  logic             err_clr,
  output logic             regar,
  output logic [1:0]       estado,
  output logic             timeout_err
);

  localparam int unsigned DRY_W = $clog2(N_CONFIRM + 1);
  localparam int unsigned ON_W  = $clog2(MAX_ON + 1);
  localparam int unsigned LK_W  = $clog2(LOCKOUT + 1);

  estado_t          state, state_next;
  logic [DRY_W-1:0] dry_cnt, dry_next;
  logic [ON_W-1:0]  on_cnt;
  logic [LK_W-1:0]  lk_cnt_unused;
  logic             on_tc, lk_tc;
  logic             tmo_set;
  logic             is_dry, is_wet;
  logic             on_en, lk_en;

  assign is_dry = (hum < HUM_W'(DRY_TH));
  assign is_wet = (hum >= HUM_W'(WET_TH));
  assign on_en  = (state == ST_REGANDO);
  assign lk_en  = (state == ST_LOCKOUT);

  // Timers restart from zero whenever their state is not active.
  contador_ciclos #(.W(ON_W), .TC(MAX_ON - 1)) u_on_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!enable || !on_en),
    .en    (on_en),
    .count (on_cnt),
    .tc_c  (on_tc)
  );

  contador_ciclos #(.W(LK_W), .TC(LOCKOUT - 1)) u_lk_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!enable || !lk_en),
    .en    (lk_en),
    .count (lk_cnt_unused),
    .tc_c  (lk_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dry_cnt     <= '0;
      regar       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_next;
      dry_cnt <= dry_next;
      regar   <= (state_next == ST_REGANDO);
      if (tmo_set) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign estado = state;

  always_comb begin
    state_next = state;
    dry_next   = dry_cnt;
    tmo_set    = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
      dry_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hum_valid && is_dry) begin
            if (N_CONFIRM == 1) begin
              state_next = ST_REGANDO;
            end else begin
              state_next = ST_CONFIRM;
              dry_next   = DRY_W'(1);
            end
          end
        end
        ST_CONFIRM: begin
          if (hum_valid) begin
            if (!is_dry) begin
              state_next = ST_IDLE;
              dry_next   = '0;
            end else if (dry_cnt == DRY_W'(N_CONFIRM - 1)) begin
              state_next = ST_REGANDO;
              dry_next   = '0;
            end else begin
              dry_next = dry_cnt + DRY_W'(1);
            end
          end
        end
        ST_REGANDO: begin
          // Wet-stop takes priority over expiry and leaves the error flag alone.
          if (hum_valid && is_wet && (on_cnt >= ON_W'(MIN_ON))) begin
            state_next = ST_LOCKOUT;
          end else if (on_tc) begin
            state_next = ST_LOCKOUT;
            tmo_set    = 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (lk_tc) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_riego.sv
// Randomized and directed bench for control_riego against a behavioural model.
module tb_control_riego;

  localparam int NC  = 3;
  localparam int MN  = 20;
  localparam int MX  = 100;
  localparam int LK  = 50;
  localparam int DRY = 1000;
  localparam int WET = 2000;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        hum_valid;
  logic [11:0] hum;
  logic        err_clr;
  logic        regar;
  logic [1:0]  estado;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // Model: dry run length, watering age (-1 when not watering), rest cycles left, error flag.
  int m_dry  = 0;
  int m_age  = -1;
  int m_rest = 0;
  int m_terr = 0;
  int m_set  = 0;

  control_riego #(
    .HUM_W(12), .DRY_TH(DRY), .WET_TH(WET), .N_CONFIRM(NC),
    .MIN_ON(MN), .MAX_ON(MX), .LOCKOUT(LK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hum_valid(hum_valid),
    .hum(hum), .err_clr(err_clr), .regar(regar), .estado(estado),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dry = 0; m_age = -1; m_rest = 0; m_terr = 0;
    end else begin
      m_set = 0;
      if (!enable) begin
        m_dry = 0; m_age = -1; m_rest = 0;
      end else if (m_age >= 0) begin
        if (hum_valid && int'(hum) >= WET && m_age >= MN) begin
          m_age = -1; m_rest = LK;
        end else if (m_age == MX - 1) begin
          m_age = -1; m_rest = LK; m_set = 1;
        end else begin
          m_age++;
        end
      end else if (m_rest > 0) begin
        m_rest--;
      end else if (hum_valid) begin
        if (int'(hum) < DRY) begin
          m_dry++;
          if (m_dry == NC) begin
            m_dry = 0; m_age = 0;
          end
        end else begin
          m_dry = 0;
        end
      end
      if (m_set != 0) m_terr = 1;
      else if (err_clr) m_terr = 0;
    end
  end

  always @(negedge clk) begin : cmp
    int es;
    if (rst_n) begin
      es = (m_age >= 0) ? 2 : ((m_rest > 0) ? 3 : ((m_dry > 0) ? 1 : 0));
      chk("model_regar", int'(regar), (m_age >= 0) ? 1 : 0);
      chk("model_estado", int'(estado), es);
      chk("model_timeout_err", int'(timeout_err), m_terr);
    end
  end

  task automatic idle_cycle();
    hum_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic sample(input logic [11:0] v);
    hum_valid = 1'b1;
    hum       = v;
    @(posedge clk); #1;
    hum_valid = 1'b0;
  endtask

  task automatic water();
    sample(12'd100); sample(12'd100); sample(12'd100);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; hum_valid = 1'b0; hum = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_regar", int'(regar), 0);
    chk("reset_estado", int'(estado), 0);
    chk("reset_terr", int'(timeout_err), 0);
    rst_n = 1'b1;

    // Threshold boundary: 1000 is not dry, 999 is.
    sample(12'd1000); chk("dry_th_1000", int'(estado), 0);
    sample(12'd999);  chk("dry_th_999", int'(estado), 1);
    sample(12'd2000); chk("confirm_abort", int'(estado), 0);

    sample(12'd500); chk("c1_estado", int'(estado), 1);
    sample(12'd600); chk("c2_regar", int'(regar), 0);
    sample(12'd700);
    chk("confirm_regar", int'(regar), 1);
    chk("confirm_estado", int'(estado), 2);

    repeat (10) idle_cycle();
    sample(12'd2500); chk("early_wet_ignored", int'(estado), 2);
    repeat (14) idle_cycle();
    sample(12'd2500);
    chk("wet_stop_regar", int'(regar), 0);
    chk("wet_stop_estado", int'(estado), 3);
    repeat (49) idle_cycle(); chk("lockout_held", int'(estado), 3);
    idle_cycle();             chk("lockout_done", int'(estado), 0);

    sample(12'd100);  chk("run_a", int'(estado), 1);
    sample(12'd200);  chk("run_b", int'(estado), 1);
    sample(12'd1500); chk("run_break", int'(estado), 0);
    sample(12'd300);
    chk("run_restart", int'(estado), 1);
    chk("run_no_regar", int'(regar), 0);
    sample(12'd1500);

    water(); chk("water_regar", int'(regar), 1);
    repeat (99) idle_cycle(); chk("max_on_before", int'(regar), 1);
    idle_cycle();
    chk("timeout_regar", int'(regar), 0);
    chk("timeout_estado", int'(estado), 3);
    chk("timeout_set", int'(timeout_err), 1);
    err_clr = 1'b1; idle_cycle(); err_clr = 1'b0;
    chk("err_clr", int'(timeout_err), 0);
    repeat (60) idle_cycle();

    water(); repeat (99) idle_cycle();
    err_clr = 1'b1; idle_cycle(); err_clr = 1'b0;
    chk("set_beats_clear", int'(timeout_err), 1);
    repeat (60) idle_cycle();

    water(); repeat (5) idle_cycle();
    enable = 1'b0; idle_cycle();
    chk("disable_regar", int'(regar), 0);
    chk("disable_estado", int'(estado), 0);
    chk("disable_keeps_err", int'(timeout_err), 1);
    enable = 1'b1;

    water(); repeat (5) idle_cycle();
    chk("pre_reset_regar", int'(regar), 1);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("async_rst_regar", int'(regar), 0);
    chk("async_rst_terr", int'(timeout_err), 0);
    chk("async_rst_estado", int'(estado), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      bit quiet;
      quiet     = ((i / 300) % 2) == 1;
      enable    = ($urandom_range(0, 199) != 0);
      err_clr   = ($urandom_range(0, 49) == 0);
      hum_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, quiet ? 3 : 5))
        0: hum = 12'($urandom_range(0, 998));
        1: hum = 12'($urandom_range(1000, 1999));
        2: hum = 12'd999;
        3: hum = 12'd1000;
        4: hum = 12'($urandom_range(2000, 4095));
        default: hum = ($urandom_range(0, 1) == 0) ? 12'd1999 : 12'd2000;
      endcase
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_riego.md
CONTROL_RIEGO -- requirements
Module: control_riego

Interface
REQ-001 SHALL have parameter HUM_W, default 12, meaning width of the moisture sample (larger value = wetter soil).
REQ-002 SHALL have parameter DRY_TH, default 1000, meaning a sample strictly below it is dry.
REQ-003 SHALL have parameter WET_TH, default 2000, meaning a sample at or above it is wet; DRY_TH < WET_TH.
REQ-004 SHALL have parameter N_CONFIRM, default 4, meaning the consecutive dry samples needed to start watering (at least 1).
REQ-005 SHALL have parameter MIN_ON, default 50_000_000, meaning the minimum watering cycles before a wet sample may stop watering.
REQ-006 SHALL have parameter MAX_ON, default 1_500_000_000, meaning the watering cycle limit; MAX_ON > MIN_ON.
REQ-007 SHALL have parameter LOCKOUT, default 500_000_000, meaning the rest cycles after watering ends.
REQ-008 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-009 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port enable  input  1  controller enable; low forces idle.
REQ-011 SHALL have port hum_valid  input  1  single-cycle strobe qualifying hum.
REQ-012 SHALL have port hum  input  HUM_W  moisture sample.
REQ-013 SHALL have port err_clr  input  1  clears timeout_err.
REQ-014 SHALL have port regar  output  1  watering request to the pump/alarm stage.
REQ-015 SHALL have port estado  output  2  current state code.
REQ-016 SHALL have port timeout_err  output  1  sticky flag: watering ended by MAX_ON.

Function
REQ-017 SHALL implement FSM IDLE=0, CONFIRM=1, REGANDO=2, LOCKOUT=3; estado = state register.
REQ-018 IDLE: valid dry sample -> CONFIRM with dry count 1, or -> REGANDO directly if N_CONFIRM=1; other samples are ignored.
REQ-019 CONFIRM: valid dry sample increments the count and goes -> REGANDO when the count reaches N_CONFIRM; a valid non-dry sample -> IDLE with count 0; cycles without hum_valid hold the state.
REQ-020 REGANDO: the on-counter starts at 0 on entry and increments every cycle, saturating.
- A valid wet sample with on-counter >= MIN_ON goes -> LOCKOUT.
- A wet sample with on-counter below MIN_ON is ignored.
REQ-021 REGANDO: when the on-counter reaches MAX_ON-1 without the stop condition, the FSM SHALL go -> LOCKOUT and set timeout_err.
REQ-022 If a wet-stop and a MAX_ON expiry occur in the same cycle, wet-stop SHALL win and timeout_err SHALL stay unchanged.
REQ-023 LOCKOUT: SHALL count LOCKOUT cycles, then go -> IDLE; all samples are ignored during LOCKOUT.
REQ-024 regar SHALL be registered and SHALL equal 1 exactly while the state is REGANDO.
- regar rises in the cycle after the edge that samples the confirming valid sample.
- regar falls in the cycle after the stop edge.
REQ-025 enable=0 SHALL force IDLE from any state on the next edge and clear all counters; regar SHALL go low on that edge; timeout_err SHALL be kept.
REQ-026 timeout_err SHALL be cleared by err_clr; if set and clear occur in the same cycle, set SHALL win.
REQ-027 Counters SHALL be sized $clog2(param+1) and SHALL never wrap.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, all counters 0, regar=0, estado=0 and timeout_err=0.
REQ-029 Reset release SHALL resume in IDLE; a reset during REGANDO SHALL drop regar immediately, without waiting for a clock edge.

Structure
REQ-030 State codes and default thresholds SHALL live in the shared package riego_pkg.
REQ-031 The on-timer and the lockout timer SHALL each be an instance of the sub-module contador_ciclos (clear, enable, terminal-count output, width parameter).

Verification (N_CONFIRM=3, MIN_ON=20, MAX_ON=100, LOCKOUT=50)
REQ-032 Sending dry samples 500, 600, 700 SHALL raise regar one cycle after the third strobe and set estado=2.
REQ-033 Sending dry, dry, 1500, dry SHALL give estado 1 -> 0 on the 1500 sample, with no regar.
REQ-034 In REGANDO, a 2500 sample at on-cycle 10 SHALL be ignored; a 2500 sample at on-cycle 25 SHALL drop regar and give estado=3, then estado=0 after 50 cycles.
REQ-035 With no wet sample, regar SHALL drop at on-cycle 100 and set timeout_err=1; err_clr SHALL then clear it.
REQ-036 Pulsing enable=0 in REGANDO SHALL give regar=0 and estado=0 on the next edge.
REQ-037 Asserting rst_n=0 asynchronously in REGANDO SHALL drop regar and timeout_err at once, with no clock edge.
